// File: rtl/sa_pkg.sv
// Shared state encoding and default configuration for the systolic-array load controller.
package sa_pkg;

  localparam int unsigned DEF_ADDR_W       = 6;
  localparam int unsigned DEF_DRAIN_CYCLES = 5;
  localparam int unsigned DEF_W_BASE       = 0;
  localparam int unsigned DEF_D_BASE       = 16;
  localparam int unsigned TILE_W           = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PRELOAD = 3'd2,
    ST_FEED    = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_FINISH  = 3'd5
  } sa_state_e;

endpackage

// File: rtl/sa_cycle_counter.sv
// Loadable down-counter with a zero flag; times the array drain window.
module sa_cycle_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load takes priority over decrement; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sa_load_controller.sv
// Sequences clear / weight preload / activation feed / drain per tile and
// arbitrates the shared single-port memory address.
// Optional feature: define SA_CTRL_ABORT_EN to add the abort input.
module sa_load_controller
  import sa_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned W_BASE       = DEF_W_BASE,
  parameter int unsigned D_BASE       = DEF_D_BASE
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SA_CTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              w_en,
  input  logic              w_done,
  input  logic [ADDR_W-1:0] w_addr,
  output logic              d_en,
  input  logic              d_done,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              sa_clear,
  output logic              busy,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  sa_state_e         state_q, state_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
  logic              w_en_q, d_en_q, sa_clear_q, busy_q, done_q;
  logic              cnt_load, cnt_dec, cnt_zero;

  // Drain timer: loaded with DRAIN_CYCLES-1 on entry so DRAIN lasts DRAIN_CYCLES cycles.
  sa_cycle_counter #(
    .W (CNT_W)
  ) u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(DRAIN_CYCLES - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state, tile bookkeeping and drain-timer control.
  always_comb begin
    state_d     = state_q;
    tile_idx_d  = tile_idx_q;
    num_tiles_d = num_tiles_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CLEAR;
          tile_idx_d  = '0;
          num_tiles_d = (num_tiles == '0) ? TILE_W'(1) : num_tiles;
        end
      end
      ST_CLEAR: state_d = ST_PRELOAD;
      ST_PRELOAD: begin
        if (w_done) state_d = ST_FEED;
      end
      ST_FEED: begin
        if (d_done) begin
          state_d  = ST_DRAIN;
          cnt_load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_zero) begin
          if (({1'b0, tile_idx_q} + (TILE_W + 1)'(1)) < {1'b0, num_tiles_q}) begin
            state_d    = ST_CLEAR;
            tile_idx_d = tile_idx_q + TILE_W'(1);
          end else begin
            state_d = ST_FINISH;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
`ifdef SA_CTRL_ABORT_EN
    // Abort jumps straight to FINISH so the job still reports completion.
    if (abort && (state_q != ST_IDLE) && (state_q != ST_FINISH)) begin
      state_d  = ST_FINISH;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
`endif
  end

  // State, tile registers and registered output strobes decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tile_idx_q  <= '0;
      num_tiles_q <= '0;
      w_en_q      <= 1'b0;
      d_en_q      <= 1'b0;
      sa_clear_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_idx_q  <= tile_idx_d;
      num_tiles_q <= num_tiles_d;
      w_en_q      <= (state_d == ST_PRELOAD);
      d_en_q      <= (state_d == ST_FEED);
      sa_clear_q  <= (state_d == ST_CLEAR);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_FINISH);
    end
  end

  // Shared memory address: source selected by the current state, wrapping at ADDR_W bits.
  always_comb begin
    mem_addr = '0;
    if (state_q == ST_PRELOAD) begin
      mem_addr = ADDR_W'(W_BASE) + w_addr;
    end else if (state_q == ST_FEED) begin
      mem_addr = ADDR_W'(D_BASE) + d_addr;
    end
  end

  assign w_en     = w_en_q;
  assign d_en     = d_en_q;
  assign sa_clear = sa_clear_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tile_idx = tile_idx_q;

endmodule

// File: doc/sa_load_controller.md
SA_LOAD_CONTROLLER -- requirements
Module: sa_load_controller

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the width of every memory address port.
REQ-002 Parameter DRAIN_CYCLES, default 5, SHALL set the cycles held in DRAIN (2N-1 for the 3x3 array).
REQ-003 Parameter W_BASE, default 0, SHALL set the weight-region base address added to each preloader address.
REQ-004 Parameter D_BASE, default 16, SHALL set the activation-region base address added to each feeder address.
REQ-005 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port start, input, 1 bit: job request; sampled only in IDLE.
REQ-008 Port num_tiles, input, 4 bits: tile count; latched when start is accepted; 0 is treated as 1.
REQ-009 Port w_en, output, 1 bit: enable to the weight preloader.
REQ-010 Port w_done, input, 1 bit: preloader is_done pulse.
REQ-011 Port w_addr, input, ADDR_W bits: preloader address.
REQ-012 Port d_en, output, 1 bit: enable to the activation feeder.
REQ-013 Port d_done, input, 1 bit: feeder completion pulse.
REQ-014 Port d_addr, input, ADDR_W bits: feeder address.
REQ-015 Port mem_addr, output, ADDR_W bits: address to the shared single-port memory.
REQ-016 Port sa_clear, output, 1 bit: one-cycle accumulator clear to the array.
REQ-017 Port busy, output, 1 bit: high in every state except IDLE.
REQ-018 Port done, output, 1 bit: one-cycle job-complete pulse.
REQ-019 Port tile_idx, output, 4 bits: index of the current tile.

Function
REQ-020 The FSM SHALL have the states IDLE, CLEAR, PRELOAD, FEED, DRAIN and FINISH.
REQ-021 IDLE SHALL go to CLEAR on start=1; it SHALL latch num_tiles and set tile_idx=0.
REQ-022 CLEAR SHALL last one cycle with sa_clear=1, then go to PRELOAD.
REQ-023 PRELOAD SHALL hold w_en=1 and go to FEED in the cycle after w_done=1; w_en SHALL drop in that same cycle.
REQ-024 FEED SHALL hold d_en=1 and go to DRAIN in the cycle after d_done=1.
REQ-025 DRAIN SHALL last exactly DRAIN_CYCLES cycles, with w_en=d_en=0.
REQ-026 After DRAIN, the FSM SHALL go to CLEAR with tile_idx+1 if tile_idx+1 < num_tiles; otherwise it SHALL go to FINISH.
REQ-027 FINISH SHALL last one cycle with done=1, then go to IDLE.
REQ-028 w_en and d_en SHALL never be high in the same cycle.
REQ-029 mem_addr SHALL be W_BASE+w_addr in PRELOAD, D_BASE+d_addr in FEED, and 0 otherwise.
REQ-030 mem_addr SHALL be combinational from the state and wrap modulo 2^ADDR_W.
REQ-031 w_done outside PRELOAD and d_done outside FEED SHALL be ignored.
REQ-032 start outside IDLE SHALL be ignored and not queued.
REQ-033 A start arriving in the FINISH cycle SHALL be dropped; a start in the next cycle (IDLE) SHALL be accepted.
REQ-034 All outputs except mem_addr SHALL be registered or decoded from the state register only.

Reset
REQ-035 rst=1 SHALL force IDLE and tile_idx=0, and clear the latched tile count and the drain counter.
REQ-036 During and after reset, w_en, d_en, sa_clear, busy and done SHALL be 0, and mem_addr SHALL be 0.
REQ-037 rst asserted mid-job SHALL abandon the job with no done pulse; the next start SHALL begin a fresh job.
REQ-038 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-039 Macro SA_CTRL_ABORT_EN, when defined, SHALL add input abort (1 bit).
REQ-040 With SA_CTRL_ABORT_EN, abort=1 in any non-IDLE state SHALL go to FINISH next cycle, dropping w_en/d_en that cycle; done SHALL still pulse.
REQ-041 Without SA_CTRL_ABORT_EN, the abort port and its logic SHALL be absent, and behaviour SHALL be as REQ-020 to REQ-034.

Structure
REQ-042 Package sa_pkg SHALL hold the state encoding and the default ADDR_W, W_BASE, D_BASE and DRAIN_CYCLES constants.
REQ-043 The drain timer SHALL be the sub-module sa_cycle_counter (load, count down, zero flag); the FSM SHALL stay in this module.

Verification
REQ-044 Single tile: num_tiles=1, start; w_done after 9 cycles, d_done after 7 -> sa_clear 1 cycle, w_en 9 cycles, d_en 7 cycles, 5 DRAIN cycles, one done pulse, busy then low.
REQ-045 Multi tile: num_tiles=3 -> three CLEAR/PRELOAD/FEED/DRAIN sequences, tile_idx 0,1,2, exactly one done.
REQ-046 Address mux: w_addr=5 in PRELOAD -> mem_addr=5; d_addr=63 in FEED with D_BASE=16 -> mem_addr=15 (wrap); mem_addr=0 in DRAIN.
REQ-047 Spurious inputs: w_done during FEED, start while busy, num_tiles=0 -> no state effect; the job runs exactly one tile.
REQ-048 Reset mid-FEED: rst for 1 cycle -> next cycle IDLE, all outputs 0, no done; a following start completes normally.
REQ-049 With SA_CTRL_ABORT_EN: abort in PRELOAD -> w_en=0 next cycle, FINISH, done pulse, then IDLE.
